// File: rtl/video_pkg.sv
// Shared timing defaults and the sync bundle
// carried down the video delay line.
package video_pkg;

   localparam int RGB_W = 24;

   localparam int DEF_H_ACTIVE = 720;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 32;
   localparam int DEF_H_BP     = 32;
   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 68;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic hblank;
      logic vblank;
      logic de;
      logic frame_start;
   } sync_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register for an arbitrary bundle type,
// used to align sync/blank timing with the pixel pipeline.
module sync_delay #(
   parameter int  DEPTH   = 2,
   parameter type T       = logic,
   parameter T    RST_VAL = '0
) (
   input  logic clk,
   input  logic reset_n,
   input  T     d,
   output T     q
);

   T stage [DEPTH];

   // shift the bundle one stage per clock
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            stage[i] <= RST_VAL;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++)
            stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_pipe.sv
// Raster counters plus sync/blank generation,
// delayed to line up with a fetch pipeline of RGB_LAT cycles.
module video_timing_pipe
   import video_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int RGB_LAT  = 1,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   localparam int XW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   localparam int YW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic             clk_vid_32_768,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             resync,
   input  logic [RGB_W-1:0] rgb_in,
   output logic [XW-1:0]    x,
   output logic [YW-1:0]    y,
   output logic             hsync,
   output logic             vsync,
   output logic             hblank,
   output logic             vblank,
   output logic             de,
   output logic [RGB_W-1:0] rgb,
   output logic             frame_start,
   output logic [15:0]      frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = HS_BEG + H_SYNC;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = VS_BEG + V_SYNC;

   localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

   localparam sync_t RST_SYNC =
      '{!HS_POL, !VS_POL, 1'b0, 1'b0, 1'b0, 1'b0};

   logic             x_wrap;
   logic             y_wrap;
   logic [31:0]      xe;
   logic [31:0]      ye;
   sync_t            sync_int;
   sync_t            sync_q;
   logic [RGB_W-1:0] rgb_q;

   assign x_wrap = (x == X_LAST);
   assign y_wrap = (y == Y_LAST);

   // raster counters; resync returns to origin without counting a frame
   always_ff @(posedge clk_vid_32_768) begin
      if (!reset_n) begin
         x           <= '0;
         y           <= '0;
         frame_count <= '0;
      end else if (resync) begin
         x <= '0;
         y <= '0;
      end else if (enable) begin
         if (x_wrap) begin
            x <= '0;
            if (y_wrap) begin
               y           <= '0;
               frame_count <= frame_count + 16'd1;
            end else begin
               y <= y + YW'(1);
            end
         end else begin
            x <= x + XW'(1);
         end
      end
   end

   // undelayed sync/blank decode from the current raster position
   always_comb begin
      sync_int = RST_SYNC;
      xe       = 32'(x);
      ye       = 32'(y);
      sync_int.hblank = (xe >= H_ACTIVE);
      sync_int.vblank = (ye >= V_ACTIVE);
      sync_int.de     = !sync_int.hblank && !sync_int.vblank;
      sync_int.hsync  = (xe >= HS_BEG && xe < HS_END)
                        ? HS_POL : !HS_POL;
      sync_int.vsync  = (ye >= VS_BEG && ye < VS_END)
                        ? VS_POL : !VS_POL;
      sync_int.frame_start = (x == '0) && (y == '0);
   end

   sync_delay #(
      .DEPTH   (RGB_LAT + 1),
      .T       (sync_t),
      .RST_VAL (RST_SYNC)
   ) u_delay (
      .clk     (clk_vid_32_768),
      .reset_n (reset_n),
      .d       (sync_int),
      .q       (sync_q)
   );

   // capture the fetched pixel; it lands with the delayed timing
   always_ff @(posedge clk_vid_32_768) begin
      if (!reset_n)
         rgb_q <= '0;
      else
         rgb_q <= rgb_in;
   end

   assign hsync       = sync_q.hsync;
   assign vsync       = sync_q.vsync;
   assign hblank      = sync_q.hblank;
   assign vblank      = sync_q.vblank;
   assign de          = sync_q.de;
   assign frame_start = sync_q.frame_start;
   assign rgb         = de ? rgb_q : '0;

endmodule
